// File: rtl/fx_pkg.sv
// rtl/fx_pkg.sv - shared constants, Q-format/accumulator types and frame state for fx_accum
package fx_pkg;
    localparam int FX_WIDTH = 32;
    localparam int FX_QINT  = 16;
    localparam int FX_ACCW  = 48;
    localparam int FX_CNTW  = 16;

    typedef logic signed [FX_WIDTH-1:0] fx_word_t;
    typedef logic signed [FX_ACCW-1:0]  fx_acc_t;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } fx_state_t;
endpackage

// File: rtl/fx_sat_narrow.sv
// rtl/fx_sat_narrow.sv - combinational ACCW->WIDTH narrowing; FX_ACCUM_SAT_EN selects clamp vs. wrap
module fx_sat_narrow #(
    parameter int WIDTH = 32,
    parameter int ACCW  = 48
) (
    input  logic signed [ACCW-1:0]  i_acc,
    output logic signed [WIDTH-1:0] o_word,
    output logic                    o_sat
);
`ifdef FX_ACCUM_SAT_EN
    // The value fits when every bit from WIDTH-1 upward matches the sign bit.
    logic w_fits;
    assign w_fits = (&i_acc[ACCW-1:WIDTH-1]) || !(|i_acc[ACCW-1:WIDTH-1]);
    assign o_word = w_fits        ? i_acc[WIDTH-1:0] :
                    i_acc[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
    assign o_sat  = !w_fits;
`else
    logic w_unused_hi;
    assign w_unused_hi = ^i_acc[ACCW-1:WIDTH];
    assign o_word      = i_acc[WIDTH-1:0];
    assign o_sat       = 1'b0;
`endif
endmodule

// File: rtl/fx_accum.sv
// rtl/fx_accum.sv - framed guard-bit accumulator with valid/ready result register
// FX_ACCUM_SAT_EN: clamp accumulator and narrowing instead of wrapping, report out_sat.
module fx_accum
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int QINT  = FX_QINT,
    parameter int ACCW  = FX_ACCW,
    parameter int CNTW  = FX_CNTW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] data_in,
    input  logic                    last_in,
    input  logic                    clear_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_sum,
    output logic [CNTW-1:0]         out_count,
    output logic                    out_sat,
    output logic                    overrun
);
    if (ACCW < WIDTH + 1 || QINT > WIDTH) begin : g_bad_params
        $error("fx_accum: need ACCW >= WIDTH+1 and QINT <= WIDTH");
    end

    fx_state_t              r_state, w_state_d;
    logic signed [ACCW-1:0] r_acc, w_acc_d, w_base, w_sext, w_sum;
    logic [CNTW-1:0]        r_cnt, w_cnt_d, w_base_cnt, w_cnt_inc;
    logic                   r_frame_sat, w_fsat_d, w_base_sat, w_add_sat;
    logic                   r_out_valid, r_out_sat, r_overrun;
    logic signed [WIDTH-1:0] r_out_sum, w_nar_word;
    logic [CNTW-1:0]        r_out_count;
    logic                   w_nar_sat, w_final_sat, w_fresh, w_done, w_load, w_drop;

    // A clear in the same cycle as a sample makes that sample the first of a new frame.
    assign w_fresh    = clear_in || (r_state == EMPTY);
    assign w_base     = w_fresh ? '0 : r_acc;
    assign w_base_cnt = w_fresh ? '0 : r_cnt;
    assign w_base_sat = w_fresh ? 1'b0 : r_frame_sat;
    assign w_sext     = {{(ACCW-WIDTH){data_in[WIDTH-1]}}, data_in};
    assign w_cnt_inc  = (&w_base_cnt) ? w_base_cnt : w_base_cnt + CNTW'(1);

`ifdef FX_ACCUM_SAT_EN
    logic signed [ACCW:0] w_raw;
    assign w_raw     = {w_base[ACCW-1], w_base} + {w_sext[ACCW-1], w_sext};
    assign w_add_sat = w_raw[ACCW] ^ w_raw[ACCW-1];
    assign w_sum     = !w_add_sat  ? w_raw[ACCW-1:0] :
                       w_raw[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} :
                                     {1'b0, {(ACCW-1){1'b1}}};
`else
    assign w_add_sat = 1'b0;
    assign w_sum     = w_base + w_sext;
`endif

    fx_sat_narrow #(
        .WIDTH (WIDTH),
        .ACCW  (ACCW)
    ) u_narrow (
        .i_acc  (w_sum),
        .o_word (w_nar_word),
        .o_sat  (w_nar_sat)
    );

    assign w_final_sat = w_base_sat | w_add_sat | w_nar_sat;
    assign w_done      = valid_in && last_in;
    assign w_load      = w_done && (!r_out_valid || out_ready);
    assign w_drop      = w_done && r_out_valid && !out_ready;

    always_comb begin
        w_state_d = r_state;
        w_acc_d   = r_acc;
        w_cnt_d   = r_cnt;
        w_fsat_d  = r_frame_sat;
        if (valid_in && !last_in) begin
            w_state_d = ACCUM;
            w_acc_d   = w_sum;
            w_cnt_d   = w_cnt_inc;
            w_fsat_d  = w_final_sat;
        end else if (w_done || clear_in) begin
            w_state_d = EMPTY;
            w_acc_d   = '0;
            w_cnt_d   = '0;
            w_fsat_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_frame_sat <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_acc       <= w_acc_d;
            r_cnt       <= w_cnt_d;
            r_frame_sat <= w_fsat_d;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_nar_word;
                r_out_count <= w_cnt_inc;
                r_out_sat   <= w_final_sat;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_fx_accum.sv
// tb/tb_fx_accum.sv - directed table-driven bench for fx_accum (Q16.16, narrow counter)
module tb_fx_accum;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in, last_in, clear_in, out_ready;
    logic [W-1:0]  data_in;
    logic          out_valid, out_sat, overrun;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;

    fx_accum #(.WIDTH(W), .QINT(16), .ACCW(48), .CNTW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .clear_in  (clear_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v, l, c, r;
        logic [W-1:0]  d;
        logic          ev;
        logic [W-1:0]  es;
        logic [CW-1:0] ec;
        logic          esat;
        logic          eovr;
    } vec_t;

    vec_t tbl[$];
    logic [W-1:0]  x_sum;
    logic [CW-1:0] x_cnt;
    logic          x_sat, x_ovr;

    task automatic step(input logic v, input logic l, input logic c, input logic r,
                        input logic [W-1:0] d, input logic ev);
        vec_t e;
        e.v = v; e.l = l; e.c = c; e.r = r; e.d = d; e.ev = ev;
        e.es = x_sum; e.ec = x_cnt; e.esat = x_sat; e.eovr = x_ovr;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic l, input logic c, input logic r, input logic [W-1:0] d);
        valid_in = v; last_in = l; clear_in = c; out_ready = r; data_in = d;
    endtask

    task automatic chk_all(input int idx, input logic ev, input logic [W-1:0] es,
                           input logic [CW-1:0] ec, input logic esat, input logic eovr);
        chk("out_valid", idx, 64'(out_valid), 64'(ev));
        chk("out_sum",   idx, 64'(out_sum),   64'(es));
        chk("out_count", idx, 64'(out_count), 64'(ec));
        chk("out_sat",   idx, 64'(out_sat),   64'(esat));
        chk("overrun",   idx, 64'(overrun),   64'(eovr));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, '0);

        x_sum = '0; x_cnt = '0; x_sat = 1'b0; x_ovr = 1'b0;
        // {1.0, 2.0, -0.5}
        step(1, 0, 0, 1, 32'h0001_0000, 0);
        step(1, 0, 0, 1, 32'h0002_0000, 0);
        x_sum = 32'h0002_8000; x_cnt = 3;
        step(1, 1, 0, 1, 32'hFFFF_8000, 1);
        step(0, 0, 0, 1, '0, 0);
        // single-sample frame in EMPTY
        x_sum = 32'hFFFF_0000; x_cnt = 1;
        step(1, 1, 0, 1, 32'hFFFF_0000, 1);
        step(0, 0, 0, 1, '0, 0);
        // back-to-back, consumer ready on the second load
        x_sum = 32'h0001_0000; x_cnt = 1;
        step(1, 1, 0, 0, 32'h0001_0000, 1);
        x_sum = 32'h0002_0000;
        step(1, 1, 0, 1, 32'h0002_0000, 1);
        step(0, 0, 0, 1, '0, 0);
        // 3 x 0x7FFF_FFFF
        step(1, 0, 0, 1, 32'h7FFF_FFFF, 0);
        step(1, 0, 0, 1, 32'h7FFF_FFFF, 0);
        x_cnt = 3;
`ifdef FX_ACCUM_SAT_EN
        x_sum = 32'h7FFF_FFFF; x_sat = 1'b1;
`else
        x_sum = 32'h7FFF_FFFD; x_sat = 1'b0;
`endif
        step(1, 1, 0, 1, 32'h7FFF_FFFF, 1);
        step(0, 0, 0, 1, '0, 0);
        // clear with a sample starts a fresh frame
        x_sat = 1'b0;
        step(1, 0, 0, 1, 32'h0005_0000, 0);
        step(1, 0, 0, 1, 32'h0005_0000, 0);
        step(1, 0, 1, 1, 32'h0001_0000, 0);
        x_sum = 32'h0003_0000; x_cnt = 2;
        step(1, 1, 0, 1, 32'h0002_0000, 1);
        step(0, 0, 0, 1, '0, 0);
        // clear alone, then last_in without valid_in is ignored
        step(1, 0, 0, 1, 32'h0005_0000, 0);
        step(0, 0, 1, 1, '0, 0);
        step(0, 1, 0, 1, 32'h0007_0000, 0);
        x_sum = 32'h0001_0000; x_cnt = 1;
        step(1, 1, 0, 1, 32'h0001_0000, 1);
        step(0, 0, 0, 1, '0, 0);
        // 20 samples: count saturates at 2^CW-1
        for (int i = 0; i < 19; i++) step(1, 0, 0, 1, 32'h1, 0);
        x_sum = 32'd20; x_cnt = 4'hF;
        step(1, 1, 0, 1, 32'h1, 1);
        step(0, 0, 0, 1, '0, 0);
        // back-to-back with consumer stalled: second frame dropped
        x_sum = 32'h0001_0000; x_cnt = 1;
        step(1, 1, 0, 0, 32'h0001_0000, 1);
        x_ovr = 1'b1;
        step(1, 1, 0, 0, 32'h0002_0000, 1);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 1, '0, 0);
        step(0, 0, 1, 1, '0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk_all(-1, 0, '0, '0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].r, tbl[i].d);
            @(posedge clk);
            #1;
            chk_all(i, tbl[i].ev, tbl[i].es, tbl[i].ec, tbl[i].esat, tbl[i].eovr);
        end

        // reset mid-frame while a result is pending
        @(negedge clk);
        drive(1, 1, 0, 0, 32'h0004_0000);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 100, 64'(out_valid), 64'(1));
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h0005_0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all(101, 0, '0, '0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 1, 0, 1, 32'h0001_0000);
        @(posedge clk);
        #1;
        chk_all(102, 1, 32'h0001_0000, 4'd1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, '0);
        @(posedge clk);
        #1;
        chk("post_rst_drain", 103, 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary, limit 200000 ns");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fx_accum.md
# fx_accum

Frame accumulator that sits directly downstream of the fixed-point multiplier in the regression datapath. It sums a stream of signed Qm.n products into a wide guard-bit accumulator over frames delimited by `last_in`. Each completed sum is narrowed back to WIDTH and presented on a valid/ready output register. It is used to form the dot products and sums of the least-squares normal equations.

## Interface
- `WIDTH`, 32: sample and result word width; same Q format as the multiplier result.
- `QINT`, 16: integer bits of the Q format, informational only. The sum keeps the same scaling, so no shift is applied.
- `ACCW`, 48: accumulator width. Must satisfy ACCW ≥ WIDTH+1.
- `CNTW`, 16: sample-counter width.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: sample strobe, driven by the multiplier's valid_out. There is no backpressure to the multiplier.
- `data_in` in WIDTH, signed: product sample.
- `last_in` in 1: qualifies the final sample of a frame. Ignored unless `valid_in` is high.
- `clear_in` in 1: synchronous discard of the partial frame.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out WIDTH, signed: narrowed frame sum.
- `out_count` out CNTW: number of samples in the frame, saturating at 2^CNTW−1.
- `out_sat` out 1: narrowing or accumulator saturation occurred in this frame. Always 0 without FX_ACCUM_SAT_EN.
- `overrun` out 1: sticky flag. A completed frame was dropped because the result register was full.

## Operation
- Internal state: `acc` (ACCW), `cnt` (CNTW), `frame_sat` (1), and a result register holding `out_sum`, `out_count`, `out_sat` and `out_valid`.
- Two states:
  - EMPTY (`acc`=0, `cnt`=0).
  - ACCUM (at least one sample taken).
  - EMPTY→ACCUM on `valid_in` with `!last_in`.
  - ACCUM→EMPTY on `valid_in && last_in`, or on `clear_in`.
  - `valid_in && last_in` in EMPTY is a single-sample frame.
- Each accepted sample: `next = acc + sext(data_in)`, `cnt+1` (saturating).
- On `last_in`:
  - Compute the final sum from `next`.
  - Narrow it to WIDTH and load the result register.
  - Reset `acc`, `cnt` and `frame_sat` to 0.
- Narrowing: `out_sum` takes the low WIDTH bits of the sum (same Q scaling). Rounding is never applied.
- Result register load rules:
  - Loads when `out_valid`=0, or when `out_valid && out_ready` in the same cycle. The load wins, so `out_valid` stays 1.
  - If it is full and not being consumed, the new result is dropped and `overrun` is set. `overrun` is cleared only by reset.
- `out_valid` drops on `out_ready` when no new result is loading. The result is held stable while `out_valid && !out_ready`.
- `clear_in`:
  - Discards `acc`, `cnt` and `frame_sat`.
  - If `valid_in` is also high, that sample starts a fresh frame, so `acc` = sext(`data_in`) and `cnt`=1. If `last_in` is also high, it completes a 1-sample frame.
  - It never affects the result register or `overrun`.
- Reset mid-frame or mid-handshake: everything is cleared asynchronously and the pending result is lost.

## Timing
- Reset values: `out_valid`=0, `out_sum`=0, `out_count`=0, `out_sat`=0, `overrun`=0. Internal `acc`, `cnt` and `frame_sat` are 0.
- Latency: the result is visible with `out_valid` high on the cycle after the edge that samples `valid_in && last_in`.
- Throughput: one sample per cycle, back-to-back frames, no bubbles.
- `out_ready` is ignored while `out_valid`=0.

## Configuration
- `FX_ACCUM_SAT_EN` defined:
  - `acc` clamps at ±ACCW limits instead of wrapping.
  - Narrowing clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - Any clamp sets `frame_sat`, which is copied to `out_sat` on load.
- Undefined: two's-complement wrap everywhere, and `out_sat` is tied to 0.

## Structure
- Package `fx_pkg`:
  - Default WIDTH/QINT/ACCW constants.
  - Typedef for the signed Q-format word.
  - Typedef for the accumulator.
  - State enum {EMPTY, ACCUM}.
- Sub-module `fx_sat_narrow`: combinational ACCW→WIDTH narrowing that outputs the narrowed word and a saturate flag. Its behaviour is selected by `FX_ACCUM_SAT_EN`.

## Test plan
All values are Q16.16; 1.0 = 0x0001_0000.
- Frame {1.0, 2.0, −0.5}, last on the third, `out_ready`=1 → next cycle `out_sum`=0x0002_8000, `out_count`=3, `out_valid` high 1 cycle.
- Single sample −1.0 with last in EMPTY → `out_sum`=0xFFFF_0000, `out_count`=1.
- Back-to-back frames {1.0} and {2.0}:
  - With `out_ready`=0: the first is held and the second is dropped, `overrun`=1, `out_sum` stays 0x0001_0000.
  - With `out_ready` high on the second load cycle: `out_sum`=0x0002_0000, `out_valid` continuous, no overrun.
- 3 samples of 0x7FFF_FFFF:
  - With SAT_EN: `out_sum`=0x7FFF_FFFF, `out_sat`=1.
  - Without: `out_sum`=0x7FFF_FFFD, `out_sat`=0.
- Samples 5.0, 5.0, then `clear_in` with `valid_in`=1 and data 1.0, then 2.0 with last → `out_sum`=0x0003_0000, `out_count`=2.
- `rst_n` low mid-frame and with `out_valid` high → all outputs 0 immediately. A post-reset frame {1.0} gives 0x0001_0000 and `out_count`=1.
